bcd_disp_scan: RTL and testbench
================================

// Module: bcd_disp_scan
// PURPOSE
//   Downstream display stage for the BCD adder/accumulator: captures its 8-bit
//   two-digit BCD sum on a load strobe and drives a 2-digit multiplexed 7-segment
//   display. Has a refresh prescaler and a scan FSM with a dark gap between digits
//   (anti-ghosting). Also does leading-zero blanking and flags invalid BCD digits.
// PARAMETERS
//   DIV            4   clk cycles each digit is lit per scan slot (>=1)
//   SEG_ACTIVE_LOW 1   1: seg and an outputs inverted (common-anode board); 0: active-high
//   BLANK_LZ       1   1: tens digit blanked when it is 0
// PORTS
//   clk     in   1  system clock, all state updates on rising edge
//   rst     in   1  synchronous, active-high reset
//   load    in   1  capture bcd_in this edge
//   bcd_in  in   8  {tens[7:4], units[3:0]} BCD sum from the adder stage
//   seg     out  7  {a,b,c,d,e,f,g}, registered, polarity per SEG_ACTIVE_LOW
//   an      out  2  digit enable {tens, units}, registered, polarity per SEG_ACTIVE_LOW
//   err     out  1  registered; 1 while the held value has a digit > 9
// BEHAVIOUR
//   Reset: hold=8'h00, err=0, prescaler=0, FSM=GAP_T, seg/an = all-off level.
//   - All-off level: 0 when SEG_ACTIVE_LOW=0, all-ones when SEG_ACTIVE_LOW=1.
//   - rst has priority over load and over all scan activity.
//   - rst asserted mid-frame takes effect at the next edge.
//   Capture: load=1 at edge N -> hold<=bcd_in and err<=(tens>9)|(units>9) at N.
//   - seg reflects the new hold value from edge N+1 (one-cycle output register).
//   - load never disturbs the FSM or prescaler; back-to-back loads: last wins.
//   FSM states: SHOW_U -> GAP_U -> SHOW_T -> GAP_T -> SHOW_U ...
//   - SHOW_x lasts DIV cycles (prescaler 0..DIV-1, wraps to 0 on leaving).
//   - GAP_x lasts exactly 1 cycle. Frame = 2*DIV+2 cycles.
//   - Prescaler width $clog2(DIV) (min 1).
//   - The first edge after reset release enters SHOW_U.
//   Outputs are registered from (state, hold), one cycle behind the state:
//   - SHOW_U: an=2'b01, seg=enc(units).
//   - SHOW_T: an=2'b10, seg=enc(tens).
//   - GAP_x: an=2'b00, seg=7'h00.
//   - Values are pre-polarity; when SEG_ACTIVE_LOW=1 both seg and an are bitwise inverted.
//   - BLANK_LZ=1 and tens==0: SHOW_T drives an=2'b00, seg=7'h00. Units is never blanked.
//   enc (pre-polarity), digit -> seg:
//   - 0 7E, 1 30, 2 6D, 3 79, 4 33, 5 5B, 6 5F, 7 70, 8 7F, 9 7B.
//   - Any digit 10..15 -> 4F ('E'); valid digits still display normally.
// TESTING (DIV=4, BLANK_LZ=1, SEG_ACTIVE_LOW=0 unless stated)
//   1 rst=1 for 2 edges -> an=00, seg=00, err=0.
//     Release -> an=01/seg=7E (units "0") for 4 cycles, tens slot an=00 (blanked).
//   2 load 8'h37 -> units slot an=01 seg=70 for 4 cycles, gap an=00 seg=00 for 1 cycle,
//     tens slot an=10 seg=79 for 4 cycles, gap; period 10 cycles.
//   3 load 8'h05 -> tens slot an=00 seg=00 (LZ blank); units seg=5B.
//     Same test with BLANK_LZ=0 -> tens slot an=10 seg=7E.
//   4 load 8'h3C -> err=1 next edge, units seg=4F, tens seg=79.
//     Then load 8'h12 -> err=0, units seg=6D, tens seg=30.
//   5 rst pulsed during SHOW_T with hold=8'h99 -> next edge an=00, seg=00, err=0,
//     hold=00; scan restarts at SHOW_U. rst and load (8'h44) on the same edge -> hold=00.
//   6 SEG_ACTIVE_LOW=1, load 8'h88 -> units slot an=2'b10, seg=7'h00;
//     gap an=2'b11, seg=7'h7F.

Source files
------------

// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: captures a two-digit BCD sum on a load strobe and drives a
// 2-digit multiplexed 7-segment display. The scan inserts a one-cycle dark gap
// between digits so the previous digit's segments never bleed into the next.
// Tens leading-zero blanking is optional, and digits above 9 are flagged on err
// and displayed as 'E'.
module bcd_disp_scan #(
  parameter int DIV            = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  // A DIV of 1 would give $clog2 = 0; keep at least one prescaler bit.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Physical "everything dark" levels for the selected board polarity.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    SHOW_U,
    GAP_U,
    SHOW_T,
    GAP_T
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [7:0]    hold;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;

  // Active-high segment pattern {a,b,c,d,e,f,g}; any non-decimal digit shows 'E'.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h4F;
    endcase
    return s;
  endfunction

  // Capture register for the displayed value and its invalid-digit flag.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= 8'h00;
      err  <= 1'b0;
    end else if (load) begin
      hold <= bcd_in;
      err  <= (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
    end
  end

  // Scan FSM with its refresh prescaler: DIV cycles per digit, 1-cycle gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP_T;
      presc <= '0;
    end else begin
      case (state)
        SHOW_U: begin
          if (presc == PRESC_LAST) begin
            presc <= '0;
            state <= GAP_U;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        GAP_U:  state <= SHOW_T;
        SHOW_T: begin
          if (presc == PRESC_LAST) begin
            presc <= '0;
            state <= GAP_T;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: state <= SHOW_U;
      endcase
    end
  end

  // Pre-polarity digit select and segment pattern for the current scan slot.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    seg_nxt = 7'h00;
    an_nxt  = 2'b00;
    case (state)
      SHOW_U: begin
        an_nxt  = 2'b01;
        seg_nxt = enc(hold[3:0]);
      end
      SHOW_T: begin
        if (!(BLANK_LZ && (hold[7:4] == 4'd0))) begin
          an_nxt  = 2'b10;
          seg_nxt = enc(hold[7:4]);
        end
      end
      default: begin
        an_nxt  = 2'b00;
        seg_nxt = 7'h00;
      end
    endcase
  end

  // Output register: applies board polarity, one cycle behind the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_nxt : seg_nxt;
      an  <= SEG_ACTIVE_LOW ? ~an_nxt  : an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Testbench for bcd_disp_scan. Four instances share the stimulus:
//   0: DIV=4, active-high, blanking on   (primary)
//   1: DIV=4, active-high, blanking off
//   2: DIV=4, active-low,  blanking on
//   3: DIV=1, active-high, blanking on
// The reference model derives each instance's outputs from the number of edges
// since reset release (position in the frame) and the held value.
module tb_bcd_disp_scan;

  logic clk = 1'b0;
  logic rst;
  logic load;
  logic [7:0] bcd_in;

  logic [3:0][6:0] seg_v;
  logic [3:0][1:0] an_v;
  logic [3:0]      err_v;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: edges since reset release, held value, error flag.
  int         m_k    = 0;
  logic [7:0] m_hold = 8'h00;
  logic       m_err  = 1'b0;

  int divs [4] = '{4, 4, 4, 1};
  bit sals [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit blzs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  bcd_disp_scan #(.DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(seg_v[0]), .an(an_v[0]), .err(err_v[0]));
  bcd_disp_scan #(.DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(seg_v[1]), .an(an_v[1]), .err(err_v[1]));
  bcd_disp_scan #(.DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut2 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(seg_v[2]), .an(an_v[2]), .err(err_v[2]));
  bcd_disp_scan #(.DIV(1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut3 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .seg(seg_v[3]), .an(an_v[3]), .err(err_v[3]));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h4F};
    return tbl[d];
  endfunction

  // Expected {an, seg} after an edge taken with k edges already since release.
  function automatic logic [8:0] exp_out(input int k, input logic [7:0] h,
                                         input int div, input bit sal, input bit blz);
    logic [8:0] r;
    int p;
    r = 9'h000;
    if (k > 0) begin
      p = (k - 1) % (2 * div + 2);
      if (p < div)
        r = {2'b01, seg_of(h[3:0])};
      else if (p > div && p <= 2 * div && !(blz && h[7:4] == 4'd0))
        r = {2'b10, seg_of(h[7:4])};
    end
    return sal ? ~r : r;
  endfunction

  // One clock: drive, advance the model, compare every instance at negedge.
  task automatic cycle(input bit r, input bit l, input logic [7:0] b);
    logic [8:0] exp [4];
    rst = r; load = l; bcd_in = b;
    for (int i = 0; i < 4; i++)
      exp[i] = r ? (sals[i] ? 9'h1FF : 9'h000)
                 : exp_out(m_k, m_hold, divs[i], sals[i], blzs[i]);
    @(posedge clk);
    if (r) begin
      m_k = 0; m_hold = 8'h00; m_err = 1'b0;
    end else begin
      m_k++;
      if (l) begin
        m_hold = b;
        m_err  = (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("model_dut%0d", i), {6'd0, err_v[i], an_v[i], seg_v[i]},
            {6'd0, m_err, exp[i]});
    end
  endtask

  typedef struct {
    bit         rst;
    bit         load;
    logic [7:0] bcd;
    logic [1:0] an;
    logic [6:0] seg;
    bit         err;
  } vec_t;

  vec_t tbl [27];

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 8'h00;

    // Reset, blanked tens frame, 37 frame, then invalid and valid reloads.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 2'b00, 7'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 2'b00, 7'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 2'b00, 7'h00, 1'b0};
    for (int i = 3; i <= 6; i++)  tbl[i] = '{1'b0, 1'b0, 8'h00, 2'b01, 7'h7E, 1'b0};
    for (int i = 7; i <= 12; i++) tbl[i] = '{1'b0, 1'b0, 8'h00, 2'b00, 7'h00, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h37, 2'b01, 7'h7E, 1'b0};
    for (int i = 14; i <= 16; i++) tbl[i] = '{1'b0, 1'b0, 8'h00, 2'b01, 7'h70, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 2'b00, 7'h00, 1'b0};
    for (int i = 18; i <= 21; i++) tbl[i] = '{1'b0, 1'b0, 8'h00, 2'b10, 7'h79, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 8'h00, 2'b00, 7'h00, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 8'h3C, 2'b01, 7'h70, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 8'h00, 2'b01, 7'h4F, 1'b1};
    tbl[25] = '{1'b0, 1'b1, 8'h12, 2'b01, 7'h4F, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 8'h00, 2'b01, 7'h6D, 1'b0};

    for (int i = 0; i < 27; i++) begin
      cycle(tbl[i].rst, tbl[i].load, tbl[i].bcd);
      check($sformatf("tbl_%0d", i), {6'd0, err_v[0], an_v[0], seg_v[0]},
            {6'd0, tbl[i].err, tbl[i].an, tbl[i].seg});
    end
    // Continue the 12 frame to its tens slot.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
    check("tens_12", {7'd0, an_v[0], seg_v[0]}, {7'd0, 2'b10, 7'h30});

    // Leading-zero blanking versus unblanked instance.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h05);
    cycle(1'b0, 1'b0, 8'h00);
    check("units_05", {7'd0, an_v[0], seg_v[0]}, {7'd0, 2'b01, 7'h5B});
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
    check("lz_blank", {7'd0, an_v[0], seg_v[0]}, {7'd0, 2'b00, 7'h00});
    check("lz_noblank", {7'd0, an_v[1], seg_v[1]}, {7'd0, 2'b10, 7'h7E});

    // Reset in the middle of a tens slot, then reset racing a load.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h99);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00);
    check("pre_rst_tens", {7'd0, an_v[0], seg_v[0]}, {7'd0, 2'b10, 7'h7B});
    cycle(1'b1, 1'b0, 8'h00);
    check("mid_rst", {6'd0, err_v[0], an_v[0], seg_v[0]}, 16'h0000);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("restart_u", {7'd0, an_v[0], seg_v[0]}, {7'd0, 2'b01, 7'h7E});
    cycle(1'b1, 1'b1, 8'h44);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("rst_over_load", {7'd0, an_v[0], seg_v[0]}, {7'd0, 2'b01, 7'h7E});

    // Active-low board polarity.
    cycle(1'b1, 1'b0, 8'h00);
    check("al_reset", {7'd0, an_v[2], seg_v[2]}, {7'd0, 2'b11, 7'h7F});
    cycle(1'b0, 1'b1, 8'h88);
    cycle(1'b0, 1'b0, 8'h00);
    check("al_units", {7'd0, an_v[2], seg_v[2]}, {7'd0, 2'b10, 7'h00});
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00);
    check("al_gap", {7'd0, an_v[2], seg_v[2]}, {7'd0, 2'b11, 7'h7F});

    // Randomized traffic against the model, including invalid digits.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 2) != 0) b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) b[7:4] = 4'd0;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
